conv_accumulator: RTL
=====================

Name: conv_accumulator

Overview:
- Sequential accumulation stage directly downstream of the 16-bit ripple adder in the DCNN datapath.
- Consumes a stream of signed 16-bit products (one per convolution-window tap) and drives them plus its running sum into one adder instance (Cin=0).
- Registers each Sum and emits one window result after WIN_SIZE terms; the result goes to the activation/pooling stage through a valid/ready handshake.

Parameters:
- DATA_W, 16, operand/accumulator width; must equal the adder width.
- WIN_SIZE, 25, terms per window (5x5 kernel); legal range 1..255.
- CNT_W, 8, counter width; must be at least clog2(WIN_SIZE+1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous abort: discard the partial window and return to IDLE.
- in_data  in  DATA_W  signed two's-complement product term.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts a term this cycle.
- out_data  out  DATA_W  window sum.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_ovf  out  1  sticky overflow flag for the current result.
- busy  out  1  high in ACCUM or HOLD.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, acc=0, cnt=0, out_data=0, out_valid=0, out_ovf=0, busy=0. in_ready is 1 after reset (combinational from state).
- Transfer: a term is accepted on a rising edge where in_valid && in_ready.
- States:
  - IDLE: in_ready=1. On a transfer: acc <= in_data + 0 (adder B operand forced to 0), cnt <= 1, ovf <= 0. Go to ACCUM, or to HOLD if WIN_SIZE==1.
  - ACCUM: in_ready=1. On a transfer: acc <= acc + in_data through the adder, cnt <= cnt+1. When cnt+1==WIN_SIZE, go to HOLD and assert out_valid next cycle.
  - HOLD: in_ready=0. out_data=acc and out_valid=1, held stable until out_ready. On out_valid && out_ready: out_valid <= 0, cnt <= 0, state <= IDLE. The next window's first term is accepted no earlier than the following cycle.
- Throughput and latency:
  - Steady state: one term per cycle; sum visible 1 cycle after the last term is accepted.
  - Minimum window period: WIN_SIZE+1 cycles with out_ready held high.
- Arithmetic:
  - Signed wrap-around modulo 2^DATA_W. Adder Cout is ignored for the result.
  - Overflow per add = (A[MSB]==B[MSB]) && (Sum[MSB]!=A[MSB]); it is ORed into sticky ovf.
  - out_ovf is valid whenever out_valid=1 and clears on the window's first term.
- Stalls: in_valid low in ACCUM holds acc and cnt; there is no timeout.
- clear: highest priority after reset. In any state it forces IDLE, acc=0, cnt=0, out_valid=0, ovf=0, even in HOLD with out_ready high. A term presented in the same cycle is dropped.
- Reset mid-window: everything returns to reset values immediately; the partial sum is lost.

Optional Feature:
- Macro: ACC_SATURATE_EN.
- Defined: on an overflowing add, acc saturates to 0x7FFF for positive overflow or 0x8000 for negative overflow. Later adds continue from the saturated value, and out_ovf still reports the event.
- Undefined: pure wrap-around as above. Saturation logic is absent, and the adder Sum feeds acc directly.

Decomposition:
- Shared package dcnn_pkg holds:
  - DATA_W and WIN_SIZE constants.
  - State enum acc_state_t {IDLE, ACCUM, HOLD}.
  - SAT_MAX=16'h7FFF and SAT_MIN=16'h8000 constants.
- One sub-module: instantiate the existing 16-bit adder as u_add (A=in_data, B=acc or 0, Cin=0). Counter, FSM and saturation stay inline.

Test Plan:
- Reset, then 25 terms of 16'd1 with out_ready=1 -> out_data=25 (0x0019), out_valid for 1 cycle, out_ovf=0, in_ready low for exactly 1 cycle.
- Terms alternating +1000/-1000 (13 positive, 12 negative) -> out_data=1000, out_ovf=0.
- 25 terms of 0x2000 -> wrap: out_data=0x2000, out_ovf=1. With ACC_SATURATE_EN: out_data=0x7FFF, out_ovf=1.
- Full window with out_ready=0 for 10 cycles -> out_data and out_valid stable, in_ready=0 throughout, in_valid ignored. Release -> next window starts cleanly at acc=first term.
- clear asserted after 12 terms, then 25 terms of 2 -> out_data=50; the partial sum is never emitted.
- rst pulsed asynchronously mid-ACCUM (between edges) -> outputs go to reset values without waiting for a clock edge. The next full window sums correctly.

Source files
------------

// File: rtl/dcnn_pkg.sv
// Shared DCNN datapath definitions: widths, window size, accumulator states
// and saturation limits.
package dcnn_pkg;

  localparam int DATA_W   = 16;
  localparam int WIN_SIZE = 25;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } acc_state_t;

  localparam logic [15:0] SAT_MAX = 16'h7FFF;
  localparam logic [15:0] SAT_MIN = 16'h8000;

endpackage

// File: rtl/conv_accumulator_adder.sv
// Ripple-carry adder used by the DCNN accumulation stage.
module conv_accumulator_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic carry;

  // Carry ripples from the LSB; each bit is a full adder.
  always_comb begin
    sum   = '0;
    carry = cin;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/conv_accumulator.sv
// Window accumulator: sums WIN_SIZE signed terms through one adder and hands
// the result downstream over valid/ready. Define ACC_SATURATE_EN to saturate.
module conv_accumulator #(
  parameter int DATA_W   = dcnn_pkg::DATA_W,
  parameter int WIN_SIZE = dcnn_pkg::WIN_SIZE,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_ovf,
  output logic              busy
);

  import dcnn_pkg::*;

  localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(WIN_SIZE);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  acc_state_t        state, state_d;
  logic [DATA_W-1:0] acc, acc_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              ovf, ovf_d;

  logic [DATA_W-1:0] add_b, add_sum, acc_new;
  logic              add_ovf, cout_unused;
  logic [CNT_W-1:0]  cnt_inc;

  // The first term of a window starts from zero rather than the stale sum.
  assign add_b = (state == IDLE) ? '0 : acc;

  conv_accumulator_adder #(.W(DATA_W)) u_add (
    .a    (in_data),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (cout_unused)
  );

  assign add_ovf = (in_data[DATA_W-1] == add_b[DATA_W-1]) &&
                   (add_sum[DATA_W-1] != in_data[DATA_W-1]);

`ifdef ACC_SATURATE_EN
  assign acc_new = add_ovf ? (in_data[DATA_W-1] ? DATA_W'(SAT_MIN) : DATA_W'(SAT_MAX))
                           : add_sum;
`else
  assign acc_new = add_sum;
`endif

  assign cnt_inc   = cnt + ONE_CNT;
  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign out_data  = acc;
  assign out_ovf   = ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_d;
      acc   <= acc_d;
      cnt   <= cnt_d;
      ovf   <= ovf_d;
    end
  end

  // clear outranks everything, including a result being taken this cycle.
  always_comb begin
    state_d = state;
    acc_d   = acc;
    cnt_d   = cnt;
    ovf_d   = ovf;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc_d   = acc_new;
            cnt_d   = ONE_CNT;
            ovf_d   = 1'b0;
            state_d = (ONE_CNT == WIN_CNT) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_d = acc_new;
            cnt_d = cnt_inc;
            ovf_d = ovf | add_ovf;
            if (cnt_inc == WIN_CNT) state_d = HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
